// File: rtl/ifb_pkg.sv
// Shared types and default parameters for the instruction fetch buffer.
package ifb_pkg;

  localparam int unsigned IFB_INST_W   = 16;
  localparam int unsigned IFB_LINE_N   = 4;
  localparam int unsigned IFB_FETCH_N  = 4;
  localparam int unsigned IFB_ADDR_W   = 16;
  localparam int unsigned IFB_RESET_PC = 0;
  localparam int unsigned IFB_STALL_W  = 16;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } ifb_state_e;

endpackage

// File: rtl/ifb_align.sv
// Combinational lane selector: builds the FETCH_N-wide window starting at
// lane 'lane' of line0, spilling into line1 when the window crosses a line.
module ifb_align
  import ifb_pkg::*;
#(
  parameter int unsigned INST_W  = IFB_INST_W,
  parameter int unsigned LINE_N  = IFB_LINE_N,
  parameter int unsigned FETCH_N = IFB_FETCH_N
) (
  input  logic [$clog2(LINE_N)-1:0]  lane,
  input  logic [LINE_N*INST_W-1:0]   line0,
  input  logic [LINE_N*INST_W-1:0]   line1,
  output logic [FETCH_N*INST_W-1:0]  inst_c
);

  // Lane 0 and slot 0 both live in the MSBs; the sum never exceeds 2*LINE_N-2.
  always_comb begin
    inst_c = '0;
    for (int k = 0; k < int'(FETCH_N); k++) begin
      if (int'(lane) + k < int'(LINE_N)) begin
        inst_c[(int'(FETCH_N) - 1 - k) * int'(INST_W) +: INST_W] =
          line0[(int'(LINE_N) - 1 - (int'(lane) + k)) * int'(INST_W) +: INST_W];
      end else begin
        inst_c[(int'(FETCH_N) - 1 - k) * int'(INST_W) +: INST_W] =
          line1[(2 * int'(LINE_N) - 1 - (int'(lane) + k)) * int'(INST_W) +: INST_W];
      end
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: streams one FETCH_N-instruction window per clock
// from an external two-line-port memory. Define IFB_STALL_CNT_EN for stall_cnt.
module instr_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int unsigned INST_W   = IFB_INST_W,
  parameter int unsigned LINE_N   = IFB_LINE_N,
  parameter int unsigned FETCH_N  = IFB_FETCH_N,
  parameter int unsigned ADDR_W   = IFB_ADDR_W,
  parameter int unsigned RESET_PC = IFB_RESET_PC
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  output logic [ADDR_W-$clog2(LINE_N)-1:0]      mem_addr0,
  output logic [ADDR_W-$clog2(LINE_N)-1:0]      mem_addr1,
  input  logic [LINE_N*INST_W-1:0]              mem_line0,
  input  logic [LINE_N*INST_W-1:0]              mem_line1,
  input  logic                                  redirect_valid,
  input  logic [ADDR_W-1:0]                     redirect_pc,
  output logic [FETCH_N*INST_W-1:0]             inst,
  output logic [ADDR_W-1:0]                     out_pc,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  input  logic [$clog2(FETCH_N+1)-1:0]          adv
`ifdef IFB_STALL_CNT_EN
  ,
  output logic [IFB_STALL_W-1:0]                stall_cnt
`endif
);

  localparam int unsigned LANE_W = $clog2(LINE_N);
  localparam int unsigned ADV_W  = $clog2(FETCH_N + 1);
  localparam int unsigned WIN_W  = FETCH_N * INST_W;

  ifb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_end;
  logic [WIN_W-1:0]    hold_q, hold_d, align_c;
  logic                holding_q, holding_d;
  logic [ADV_W-1:0]    adv_clamp;
  logic                xfer;

  assign out_valid = (state_q == STREAM);
  assign xfer      = out_valid && out_ready;
  assign adv_clamp = (adv > ADV_W'(FETCH_N)) ? ADV_W'(FETCH_N) : adv;

  ifb_align #(
    .INST_W  (INST_W),
    .LINE_N  (LINE_N),
    .FETCH_N (FETCH_N)
  ) u_align (
    .lane   (pc_q[LANE_W-1:0]),
    .line0  (mem_line0),
    .line1  (mem_line1),
    .inst_c (align_c)
  );

  // Next-PC drives the memory address so data lines up with pc_q next cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    holding_d = holding_q;
    if (!rst_n) begin
      pc_d = ADDR_W'(RESET_PC);
    end else if (redirect_valid) begin
      state_d   = FILL;
      pc_d      = redirect_pc;
      holding_d = 1'b0;
    end else if (state_q == FILL) begin
      state_d = STREAM;
    end else if (xfer) begin
      pc_d      = pc_q + ADDR_W'(adv_clamp);
      holding_d = 1'b0;
    end else if (!holding_q) begin
      hold_d    = align_c;
      holding_d = 1'b1;
    end
  end

  assign pc_end    = pc_d + ADDR_W'(FETCH_N - 1);
  assign mem_addr0 = pc_d[ADDR_W-1:LANE_W];
  assign mem_addr1 = pc_end[ADDR_W-1:LANE_W];
  assign inst      = holding_q ? hold_q : align_c;
  assign out_pc    = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      pc_q      <= ADDR_W'(RESET_PC);
      hold_q    <= '0;
      holding_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      holding_q <= holding_d;
    end
  end

`ifdef IFB_STALL_CNT_EN
  logic [IFB_STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of presented-but-not-accepted cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + IFB_STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer with a behavioural memory and
// a window-level reference model; also covers stall_cnt when IFB_STALL_CNT_EN.
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] mem_addr0, mem_addr1;
  logic [63:0] mem_line0, mem_line1;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [63:0] inst;
  logic [15:0] out_pc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  adv;
`ifdef IFB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_buffer #(
    .INST_W(16), .LINE_N(4), .FETCH_N(4), .ADDR_W(16), .RESET_PC(32'h0010)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
    .mem_line0(mem_line0), .mem_line1(mem_line1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst(inst), .out_pc(out_pc), .out_valid(out_valid),
    .out_ready(out_ready), .adv(adv)
`ifdef IFB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Instruction stored at each address: a bijective scramble of the address.
  function automatic logic [15:0] f(input logic [15:0] a);
    return 16'(a * 16'd40503 + 16'd4660);
  endfunction

  function automatic logic [63:0] window(input logic [15:0] pc);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[(3 - k) * 16 +: 16] = f(pc + 16'(k));
    return w;
  endfunction

  function automatic logic [63:0] line_of(input logic [13:0] la);
    logic [63:0] w;
    for (int l = 0; l < 4; l++) w[(3 - l) * 16 +: 16] = f({la, 2'(l)});
    return w;
  endfunction

  // External memory: one-cycle read latency, optional random garbage on the bus.
  logic [13:0] ra0, ra1;
  logic        noise;
  logic [63:0] n0, n1;
  always @(posedge clk) begin
    ra0 <= mem_addr0;
    ra1 <= mem_addr1;
  end
  always_comb begin
    mem_line0 = noise ? n0 : line_of(ra0);
    mem_line1 = noise ? n1 : line_of(ra1);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    n0 = {$urandom, $urandom};
    n1 = {$urandom, $urandom};
  endtask

  typedef struct {
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic [2:0]  adv;
    logic        chk;
    logic        vld;
    logic [15:0] pc;
    logic [13:0] a0;
    logic [13:0] a1;
  } vec_t;

  vec_t tbl[16];

  logic [15:0] m_pc, npc, sc0;
  logic        m_valid, prev_stall;
  int unsigned m_stall;

  initial begin
    tbl[0]  = '{1'b1, 16'h0100, 1'b1, 3'd4, 1'b0, 1'b0, 16'h0000, 14'h0040, 14'h0040};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b1, 1'b0, 16'h0000, 14'h0040, 14'h0040};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b1, 1'b1, 16'h0100, 14'h0040, 14'h0040};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 3'd7, 1'b1, 1'b1, 16'h0100, 14'h0041, 14'h0041};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 3'd3, 1'b1, 1'b1, 16'h0104, 14'h0041, 14'h0042};
    tbl[5]  = '{1'b1, 16'h0102, 1'b1, 3'd3, 1'b1, 1'b1, 16'h0107, 14'h0040, 14'h0041};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 3'd4, 1'b1, 1'b0, 16'h0000, 14'h0040, 14'h0041};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 3'd4, 1'b1, 1'b1, 16'h0102, 14'h0041, 14'h0042};
    tbl[8]  = '{1'b1, 16'hFFFE, 1'b1, 3'd4, 1'b1, 1'b1, 16'h0106, 14'h3FFF, 14'h0000};
    tbl[9]  = '{1'b1, 16'h0003, 1'b1, 3'd4, 1'b1, 1'b0, 16'h0000, 14'h0000, 14'h0001};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 3'd1, 1'b1, 1'b0, 16'h0000, 14'h0000, 14'h0001};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 3'd4, 1'b1, 1'b1, 16'h0003, 14'h0000, 14'h0001};
    tbl[12] = '{1'b1, 16'hFFFE, 1'b1, 3'd4, 1'b1, 1'b1, 16'h0003, 14'h3FFF, 14'h0000};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 3'd4, 1'b1, 1'b0, 16'h0000, 14'h3FFF, 14'h0000};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 3'd4, 1'b1, 1'b1, 16'hFFFE, 14'h0000, 14'h0001};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 3'd4, 1'b1, 1'b1, 16'h0002, 14'h0001, 14'h0002};

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b1; adv = 3'd4; noise = 1'b0; n0 = '0; n1 = '0;

    // Reset values and release
    repeat (3) next_cycle();
    #3;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", 64'(out_pc), 64'h0010);
    check("rst_addr0", 64'(mem_addr0), 64'h4);
    check("rst_addr1", 64'(mem_addr1), 64'h4);
`ifdef IFB_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    next_cycle();
    rst_n = 1'b1;
    #3;
    check("fill_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #3;
      check($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d_pc", i), 64'(out_pc), 64'(16'h0010 + 16'(4 * i)));
      check($sformatf("stream%0d_inst", i), inst, window(16'h0010 + 16'(4 * i)));
    end

    // Five-cycle stall with garbage on the memory bus after the first cycle
    next_cycle();
    out_ready = 1'b0;
    #3;
    check("stall0_pc", 64'(out_pc), 64'h001C);
    check("stall0_inst", inst, window(16'h001C));
`ifdef IFB_STALL_CNT_EN
    sc0 = stall_cnt;
`endif
    for (int i = 1; i < 5; i++) begin
      next_cycle();
      noise = 1'b1;
      #3;
      check($sformatf("stall%0d_pc", i), 64'(out_pc), 64'h001C);
      check($sformatf("stall%0d_inst", i), inst, window(16'h001C));
    end
    next_cycle();
    out_ready = 1'b1; adv = 3'd2;
    #3;
    check("unstall_inst", inst, window(16'h001C));
    check("unstall_pc", 64'(out_pc), 64'h001C);
`ifdef IFB_STALL_CNT_EN
    check("stall_cnt_plus5", 64'(stall_cnt), 64'(sc0 + 16'd5));
`endif
    next_cycle();
    noise = 1'b0; out_ready = 1'b0;
    #3;
    check("adv2_pc", 64'(out_pc), 64'h001E);
    next_cycle();
    noise = 1'b1;
    #3;
    check("hold2_inst", inst, window(16'h001E));

    // Reset during a stall and a redirect discards everything
    next_cycle();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h1234;
    #3;
    check("rst_mid_addr0", 64'(mem_addr0), 64'h4);
    next_cycle();
    rst_n = 1'b1; redirect_valid = 1'b0; noise = 1'b0;
    #3;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_pc", 64'(out_pc), 64'h0010);
`ifdef IFB_STALL_CNT_EN
    check("rst_mid_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    next_cycle();
    #3;
    check("rst_mid_stream_valid", 64'(out_valid), 64'd1);
    check("rst_mid_stream_inst", inst, window(16'h0010));
    next_cycle();
    out_ready = 1'b1; adv = 3'd0;
    #3;
    check("adv0_pc", 64'(out_pc), 64'h0010);
    check("adv0_inst", inst, window(16'h0010));
    next_cycle();

    // Randomized run against the window-level model
    m_pc = 16'h0010; m_valid = 1'b1; prev_stall = 1'b0; m_stall = 1;
    for (int c = 0; c < 500; c++) begin
      redirect_valid = ($urandom % 10) == 0;
      redirect_pc = (($urandom % 4) == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
      out_ready = ($urandom % 10) < 7;
      adv = 3'($urandom_range(0, 7));
      noise = prev_stall ? 1'($urandom % 2) : 1'b0;
      if (redirect_valid) npc = redirect_pc;
      else if (m_valid && out_ready) npc = m_pc + ((adv > 3'd4) ? 16'd4 : 16'(adv));
      else npc = m_pc;
      #3;
      check("rnd_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        check("rnd_pc", 64'(out_pc), 64'(m_pc));
        check("rnd_inst", inst, window(m_pc));
      end
      check("rnd_addr0", 64'(mem_addr0), 64'(npc >> 2));
      check("rnd_addr1", 64'(mem_addr1), 64'(16'(npc + 16'd3) >> 2));
`ifdef IFB_STALL_CNT_EN
      check("rnd_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
      if (m_valid && !out_ready && m_stall < 65535) m_stall++;
      prev_stall = m_valid && !out_ready && !redirect_valid;
      m_valid = !redirect_valid;
      m_pc = npc;
      next_cycle();
    end

    // Directed vectors: adv 0/7, redirect during transfer, back-to-back, wrap
    noise = 1'b0;
    for (int i = 0; i < 16; i++) begin
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      out_ready = tbl[i].rdy;
      adv = tbl[i].adv;
      #3;
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].vld));
        if (tbl[i].vld) begin
          check($sformatf("tbl%0d_pc", i), 64'(out_pc), 64'(tbl[i].pc));
          check($sformatf("tbl%0d_inst", i), inst, window(tbl[i].pc));
        end
      end
      check($sformatf("tbl%0d_addr0", i), 64'(mem_addr0), 64'(tbl[i].a0));
      check($sformatf("tbl%0d_addr1", i), 64'(mem_addr1), 64'(tbl[i].a1));
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 Parameters SHALL be: INST_W, default 16, instruction width; LINE_N, default 4, instructions per memory line (power of 2); FETCH_N, default 4, instructions presented per cycle (1..LINE_N); ADDR_W, default 16, PC width; RESET_PC, default 0, fetch PC after reset.
REQ-002 Clock/reset SHALL be: clk, in, 1, sole clock; rst_n, in, 1, synchronous active-low reset.
REQ-003 Memory port SHALL be: mem_addr0, out, ADDR_W-log2(LINE_N), line holding fetch PC; mem_addr1, out, same, line holding fetch PC+FETCH_N-1; mem_line0/mem_line1, in, LINE_N*INST_W, read data one clk after address, lowest address in MSBs.
REQ-004 Control SHALL be: redirect_valid, in, 1, load new PC; redirect_pc, in, ADDR_W, target.
REQ-005 Consumer SHALL be: inst, out, FETCH_N*INST_W, slot k = instruction at pc+k, slot 0 in MSBs; out_pc, out, ADDR_W, PC of slot 0; out_valid, out, 1; out_ready, in, 1; adv, in, clog2(FETCH_N+1), instructions consumed.

Function
REQ-006 States SHALL be FILL (address issued, no valid data) and STREAM (out_valid=1); each cycle in FILL SHALL move to STREAM.
REQ-007 Addresses SHALL be computed combinationally from next-PC so a new line pair is read every cycle; throughput one window per clk.
REQ-008 Slot k SHALL come from mem_line0 when (pc mod LINE_N)+k < LINE_N, else from mem_line1 at lane (pc+k) mod LINE_N.
REQ-009 A transfer SHALL occur when out_valid && out_ready; then pc <= pc+adv, modulo 2^ADDR_W; line index wraps likewise.
REQ-010 adv=0 with transfer SHALL leave pc unchanged; adv>FETCH_N SHALL be clamped to FETCH_N.
REQ-011 When out_valid && !out_ready, inst and out_pc SHALL be held stable from an internal hold register, independent of mem_line inputs, until transfer or redirect.
REQ-012 redirect_valid SHALL take priority over transfer: pc <= redirect_pc, state <= FILL, out_valid=0 next cycle, valid data the cycle after.
REQ-013 Redirect-to-valid latency SHALL be 2 clks (redirect cycle, one bubble); back-to-back redirects SHALL keep only the latest.
REQ-014 Consumed instructions SHALL never be presented again except via redirect.

Reset
REQ-015 While rst_n=0 at clk edge: pc <= RESET_PC, state <= FILL, out_valid <= 0, hold register <= 0, out_pc <= RESET_PC.
REQ-016 mem_addr0/1 SHALL reflect RESET_PC during reset; first out_valid SHALL be the second clk edge after rst_n rises.
REQ-017 Reset mid-stall or mid-redirect SHALL discard all pending state.

Configuration
REQ-018 Macro IFB_STALL_CNT_EN SHALL add output stall_cnt (16 bits): counts cycles with out_valid && !out_ready, saturates at 0xFFFF, cleared by reset, unchanged by redirect.
REQ-019 Without IFB_STALL_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-020 Package ifb_pkg SHALL hold the state enum (FILL, STREAM) and default parameter constants.
REQ-021 Lane selection (REQ-008) SHALL be sub-module ifb_align, purely combinational, parameterised by INST_W, LINE_N, FETCH_N.
REQ-022 Memory SHALL be external; block SHALL not instantiate storage beyond hold register and state.

Verification
REQ-023 Reset, RESET_PC=0x0010, out_ready=1, adv=4: out_valid at 2nd edge, out_pc 0x0010, 0x0014, 0x0018 on consecutive cycles.
REQ-024 pc=0x0003, defaults: inst = line0 lane3, line1 lanes 0,1,2; mem_addr0=0, mem_addr1=1.
REQ-025 out_ready=0 for 5 cycles while mem_line toggles randomly: inst/out_pc constant; with IFB_STALL_CNT_EN stall_cnt +5.
REQ-026 redirect_valid with redirect_pc=0x0102 during transfer adv=3: next out_valid=0, following cycle out_pc=0x0102.
REQ-027 pc=0xFFFE, adv=4: mem_addr1=0 (wrap), slots 2,3 from address 0x0000,0x0001; next out_pc=0x0002.
REQ-028 adv=0 and adv=7 with transfer: pc unchanged and pc+4 respectively.
